// File: rtl/mux8_scan_rx_pkg.sv
// Shared types and constants for the 74HC151 scan receiver.
package mux8_scan_pkg;

    // Controller states: waiting, stepping through the 8 slots, one-cycle word hand-off.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    // The external mux has 8 data inputs addressed by a 3-bit select.
    localparam int NSLOTS = 8;
    localparam int SEL_W  = 3;

    // Width needed to count 0..n-1; never narrower than one bit.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux8_scan_rx_if.sv
// Signal bundle between the scan receiver, the board-level mux pins and the host logic.
interface mux8_scan_rx_if;
    import mux8_scan_pkg::*;

    logic                start;
    logic                mux_y;
    logic                mux_en_n;
    logic [SEL_W-1:0]    mux_sel;
    logic                busy;
    logic [NSLOTS-1:0]   data_out;
    logic                data_valid;

    // The receiver drives the mux controls and the assembled word.
    modport master (
        input  start,
        input  mux_y,
        output mux_en_n,
        output mux_sel,
        output busy,
        output data_out,
        output data_valid
    );

    // The surroundings: host requests scans, the mux returns Y.
    modport slave (
        output start,
        output mux_y,
        input  mux_en_n,
        input  mux_sel,
        input  busy,
        input  data_out,
        input  data_valid
    );

endinterface

// File: rtl/mux8_scan_rx_sync2.sv
// Generic two-flop synchroniser for a single asynchronous bit.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [1:0] stage;

    // Shift the asynchronous input through two flops to resolve metastability.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage <= 2'b00;
        end else begin
            stage <= {stage[0], d};
        end
    end

    assign q = stage[1];

endmodule

// File: rtl/mux8_scan_rx.sv
// Receive-side controller for an external 74HC151 8-to-1 mux: steps the select
// through all inputs, samples Y once per slot and returns the 8 samples as a byte.
// SETTLE_CYC must be at least 1; each slot lasts SETTLE_CYC+2 cycles so that the
// synchroniser output reflects the current select before it is sampled.
module mux8_scan_rx
    import mux8_scan_pkg::*;
#(
    parameter int SETTLE_CYC = 2,
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic           clk,
    input  logic           rst_n,
    mux8_scan_rx_if.master bus
);

    localparam int                 SLOT      = SETTLE_CYC + 2;
    localparam int                 CNT_W     = clog2(SLOT);
    localparam logic [CNT_W-1:0]   SLOT_LAST = CNT_W'(SLOT - 1);
    localparam logic [SEL_W-1:0]   SEL_LAST  = SEL_W'(NSLOTS - 1);

    state_t              state;
    logic [CNT_W-1:0]    slot_cnt;
    logic [SEL_W-1:0]    sel_r;
    logic                en_n_r;
    logic                busy_r;
    logic [NSLOTS-1:0]   shadow;
    logic [NSLOTS-1:0]   word_next;
    logic [NSLOTS-1:0]   data_out_r;
    logic                data_valid_r;
    logic                y_s;

    sync2 u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.mux_y),
        .q     (y_s)
    );

    // Shadow word with the current slot's synchronised sample merged in; this is
    // what gets stored at a slot boundary and, on the last slot, published.
    always_comb begin
        word_next        = shadow;
        word_next[sel_r] = y_s;
    end

    // Scan sequencer: every output is a flop, so select and enable never glitch.
    // The finished word is loaded into data_out on the edge that enters DONE, so
    // data_out already carries the new word during the single data_valid cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            slot_cnt     <= '0;
            sel_r        <= '0;
            en_n_r       <= 1'b1;
            busy_r       <= 1'b0;
            shadow       <= '0;
            data_out_r   <= '0;
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= 1'b0;
            case (state)
                IDLE: begin
                    en_n_r   <= 1'b1;
                    sel_r    <= '0;
                    busy_r   <= 1'b0;
                    slot_cnt <= '0;
                    if (bus.start) begin
                        state  <= SCAN;
                        en_n_r <= 1'b0;
                        busy_r <= 1'b1;
                        shadow <= '0;
                    end
                end
                SCAN: begin
                    if (slot_cnt == SLOT_LAST) begin
                        shadow   <= word_next;
                        slot_cnt <= '0;
                        if (sel_r == SEL_LAST) begin
                            state        <= DONE;
                            data_out_r   <= word_next;
                            data_valid_r <= 1'b1;
                        end else begin
                            sel_r <= sel_r + 1'b1;
                        end
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                    end
                end
                DONE: begin
                    sel_r    <= '0;
                    slot_cnt <= '0;
                    if (CONTINUOUS) begin
                        state <= SCAN;
                    end else begin
                        state  <= IDLE;
                        en_n_r <= 1'b1;
                        busy_r <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    en_n_r <= 1'b1;
                    sel_r  <= '0;
                    busy_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mux_en_n   = en_n_r;
    assign bus.mux_sel    = sel_r;
    assign bus.busy       = busy_r;
    assign bus.data_out   = data_out_r;
    assign bus.data_valid = data_valid_r;

endmodule

// File: tb/tb_mux8_scan_rx.sv
// Directed bench for mux8_scan_rx with behavioural 74HC151 models on three
// instances: default one-shot, continuous rescan, and a one-cycle settle time.
module tb_mux8_scan_rx;

    logic       clk;
    logic       rst_n;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
    int         checks;
    int         errors;
    int         dv0;
    int         dv1;
    int         dv2;

    mux8_scan_rx_if ifc0 ();
    mux8_scan_rx_if ifc1 ();
    mux8_scan_rx_if ifc2 ();

    mux8_scan_rx #(.SETTLE_CYC(2), .CONTINUOUS(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(ifc0));
    mux8_scan_rx #(.SETTLE_CYC(2), .CONTINUOUS(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(ifc1));
    mux8_scan_rx #(.SETTLE_CYC(1), .CONTINUOUS(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(ifc2));

    // 74HC151 behaviour: Y forced low while disabled, otherwise D[S].
    assign ifc0.mux_y = ifc0.mux_en_n ? 1'b0 : d0[ifc0.mux_sel];
    assign ifc1.mux_y = ifc1.mux_en_n ? 1'b0 : d1[ifc1.mux_sel];
    assign ifc2.mux_y = ifc2.mux_en_n ? 1'b0 : d2[ifc2.mux_sel];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count data_valid pulses per instance so missing or extra words show up.
    always @(posedge clk) begin
        if (ifc0.data_valid === 1'b1) dv0 <= dv0 + 1;
        if (ifc1.data_valid === 1'b1) dv1 <= dv1 + 1;
        if (ifc2.data_valid === 1'b1) dv2 <= dv2 + 1;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] selOf(input int w);
        case (w)
            0:       return {5'b0, ifc0.mux_sel};
            1:       return {5'b0, ifc1.mux_sel};
            default: return {5'b0, ifc2.mux_sel};
        endcase
    endfunction

    function automatic logic enOf(input int w);
        case (w)
            0:       return ifc0.mux_en_n;
            1:       return ifc1.mux_en_n;
            default: return ifc2.mux_en_n;
        endcase
    endfunction

    function automatic logic busyOf(input int w);
        case (w)
            0:       return ifc0.busy;
            1:       return ifc1.busy;
            default: return ifc2.busy;
        endcase
    endfunction

    function automatic logic validOf(input int w);
        case (w)
            0:       return ifc0.data_valid;
            1:       return ifc1.data_valid;
            default: return ifc2.data_valid;
        endcase
    endfunction

    function automatic logic [7:0] doutOf(input int w);
        case (w)
            0:       return ifc0.data_out;
            1:       return ifc1.data_out;
            default: return ifc2.data_out;
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One-cycle start pulse; returns at the first negedge after the accepting edge.
    task automatic applyStimulus(input int w);
        @(negedge clk);
        case (w)
            0:       ifc0.start = 1'b1;
            1:       ifc1.start = 1'b1;
            default: ifc2.start = 1'b1;
        endcase
        @(negedge clk);
        ifc0.start = 1'b0;
        ifc1.start = 1'b0;
        ifc2.start = 1'b0;
    endtask

    // Follow one non-continuous scan cycle by cycle; sample t lies between edges t-1 and t.
    task automatic watchScan(input int w, input int slot, input logic [7:0] word, input int poke_t);
        int last;
        int exp_sel;
        last = 8 * slot + 1;
        for (int t = 1; t <= last; t++) begin
            if (t > 1) @(negedge clk);
            if (w == 0) ifc0.start = (t == poke_t);
            exp_sel = ((t - 1) / slot > 7) ? 7 : (t - 1) / slot;
            checkOutput($sformatf("en_n%0d t=%0d", w, t), enOf(w), 0);
            checkOutput($sformatf("sel%0d t=%0d", w, t), selOf(w), exp_sel);
            checkOutput($sformatf("busy%0d t=%0d", w, t), busyOf(w), 1);
            checkOutput($sformatf("valid%0d t=%0d", w, t), validOf(w), (t == last));
        end
        checkOutput($sformatf("word%0d", w), doutOf(w), word);
        @(negedge clk);
        ifc0.start = 1'b0;
        checkOutput($sformatf("idle_en_n%0d", w), enOf(w), 1);
        checkOutput($sformatf("idle_busy%0d", w), busyOf(w), 0);
        checkOutput($sformatf("idle_sel%0d", w), selOf(w), 0);
        checkOutput($sformatf("idle_valid%0d", w), validOf(w), 0);
        checkOutput($sformatf("hold_word%0d", w), doutOf(w), word);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        dv0        = 0;
        dv1        = 0;
        dv2        = 0;
        rst_n      = 1'b0;
        ifc0.start = 1'b0;
        ifc1.start = 1'b0;
        ifc2.start = 1'b0;
        d0         = 8'hA5;
        d1         = 8'h3C;
        d2         = 8'h5A;

        // Reset values on every instance.
        repeat (3) @(negedge clk);
        for (int w = 0; w < 3; w++) begin
            checkOutput($sformatf("rst_en_n%0d", w), enOf(w), 1);
            checkOutput($sformatf("rst_sel%0d", w), selOf(w), 0);
            checkOutput($sformatf("rst_busy%0d", w), busyOf(w), 0);
            checkOutput($sformatf("rst_dout%0d", w), doutOf(w), 8'h00);
            checkOutput($sformatf("rst_valid%0d", w), validOf(w), 0);
        end
        rst_n = 1'b1;

        // Abort a D=A5 scan at cycle 17 with an asynchronous reset.
        applyStimulus(0);
        repeat (16) @(negedge clk);
        checkOutput("pre_abort_sel", selOf(0), 4);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_en_n", enOf(0), 1);
        checkOutput("abort_sel", selOf(0), 0);
        checkOutput("abort_busy", busyOf(0), 0);
        checkOutput("abort_dout", doutOf(0), 8'h00);
        checkOutput("abort_valid", validOf(0), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("abort_no_pulse", dv0, 0);
        checkOutput("abort_dout_hold", doutOf(0), 8'h00);

        // Fresh scan after the abort returns the full word.
        applyStimulus(0);
        watchScan(0, 4, 8'hA5, 0);
        checkOutput("pulses_a5", dv0, 1);

        // Main D=D5 scan.
        d0 = 8'hD5;
        applyStimulus(0);
        watchScan(0, 4, 8'hD5, 0);
        checkOutput("pulses_d5", dv0, 2);

        // All-zero then all-one inputs.
        d0 = 8'h00;
        applyStimulus(0);
        watchScan(0, 4, 8'h00, 0);
        checkOutput("pulses_00", dv0, 3);
        d0 = 8'hFF;
        applyStimulus(0);
        watchScan(0, 4, 8'hFF, 0);
        checkOutput("pulses_ff", dv0, 4);

        // A start pulse at cycle 10 of an active scan is dropped, not queued.
        d0 = 8'h96;
        applyStimulus(0);
        watchScan(0, 4, 8'h96, 10);
        repeat (40) @(negedge clk);
        checkOutput("ignored_start_busy", busyOf(0), 0);
        checkOutput("ignored_start_en_n", enOf(0), 1);
        checkOutput("ignored_start_pulses", dv0, 5);

        // One-cycle settle time: 3-cycle slots, word after 25 cycles.
        applyStimulus(2);
        watchScan(2, 3, 8'h5A, 0);
        checkOutput("pulses_settle1", dv2, 1);

        // Continuous rescan: back-to-back words with the enable held low.
        applyStimulus(1);
        for (int t = 1; t <= 66; t++) begin
            if (t > 1) @(negedge clk);
            checkOutput($sformatf("cont_en_n t=%0d", t), enOf(1), 0);
            checkOutput($sformatf("cont_busy t=%0d", t), busyOf(1), 1);
            checkOutput($sformatf("cont_valid t=%0d", t), validOf(1), (t == 33 || t == 66));
            if (t == 33) begin
                checkOutput("cont_word1", doutOf(1), 8'h3C);
                d1 = 8'hC3;
            end
            if (t == 66) begin
                checkOutput("cont_word2", doutOf(1), 8'hC3);
            end
        end
        @(negedge clk);
        checkOutput("cont_en_n_after", enOf(1), 0);
        checkOutput("cont_sel_restart", selOf(1), 0);
        checkOutput("cont_pulses", dv1, 2);
        checkOutput("oneshot_quiet", dv0, 5);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
